// File: rtl/spi_reg_controller.sv
// SPI register-access controller: turns received SPI bytes into req/ack register
// reads and writes, and returns read data through the peripheral's tx load port.
module spi_reg_controller #(
  parameter int         BUS_TIMEOUT = 16,
  parameter logic [7:0] RD_ERR_BYTE = 8'hEE
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rxDataValid,
  input  logic [7:0] i_rxData,
  output logic       o_txDataValid,
  output logic [7:0] o_txData,
  input  logic       i_spiCs_n,
  output logic       o_busReq,
  output logic       o_busWe,
  output logic [6:0] o_busAddr,
  output logic [7:0] o_busWdata,
  input  logic       i_busAck,
  input  logic [7:0] i_busRdata,
  output logic       o_busy,
  output logic       o_err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CMD     = 3'd1;
  localparam logic [2:0] S_WR_WAIT = 3'd2;
  localparam logic [2:0] S_WR_BUS  = 3'd3;
  localparam logic [2:0] S_RD_BUS  = 3'd4;
  localparam logic [2:0] S_RD_LOAD = 3'd5;
  localparam logic [2:0] S_RD_WAIT = 3'd6;

  localparam int               CNT_W    = $clog2(BUS_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             r_cs_meta, r_cs_sync, r_cs_prev;
  logic [2:0]       r_state;
  logic [6:0]       r_addr;
  logic             r_bus_req, r_bus_we;
  logic [6:0]       r_bus_addr;
  logic [7:0]       r_bus_wdata;
  logic [CNT_W-1:0] r_cnt;
  logic             r_tx_valid;
  logic [7:0]       r_tx_data;
  logic             r_err, r_busy;

  logic       w_cs_fall, w_cs_high, w_ack, w_timeout, w_bus_done;
  logic [2:0] w_state_nxt;
  logic       w_issue, w_issue_we;
  logic [6:0] w_issue_addr, w_addr_nxt;
  logic [7:0] w_issue_wdata, w_tx_byte;
  logic       w_tx_load, w_overrun;

  assign w_cs_fall  = r_cs_prev & ~r_cs_sync;
  assign w_cs_high  = r_cs_sync;
  assign w_ack      = r_bus_req & i_busAck;
  assign w_timeout  = r_bus_req & ~i_busAck & (r_cnt == CNT_LAST);
  assign w_bus_done = w_ack | w_timeout;

  // Chip select is asynchronous: two sync flops plus a delayed copy for edge detect
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cs_meta <= 1'b1;
      r_cs_sync <= 1'b1;
      r_cs_prev <= 1'b1;
    end else begin
      r_cs_meta <= i_spiCs_n;
      r_cs_sync <= r_cs_meta;
      r_cs_prev <= r_cs_sync;
    end
  end

  // A CS release still lets the current rx byte be latched, but then forces IDLE
  always_comb begin
    w_state_nxt   = r_state;
    w_issue       = 1'b0;
    w_issue_we    = 1'b0;
    w_issue_addr  = r_addr;
    w_issue_wdata = r_bus_wdata;
    w_addr_nxt    = r_addr;
    w_tx_load     = 1'b0;
    w_tx_byte     = r_tx_data;
    w_overrun     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cs_fall) w_state_nxt = S_CMD;
        else           w_state_nxt = S_IDLE;
      end
      S_CMD: begin
        if (i_rxDataValid) begin
          w_addr_nxt = i_rxData[6:0];
          if (w_cs_high) begin
            w_state_nxt = S_IDLE;
          end else if (i_rxData[7]) begin
            w_state_nxt  = S_RD_BUS;
            w_issue      = 1'b1;
            w_issue_addr = i_rxData[6:0];
          end else begin
            w_state_nxt = S_WR_WAIT;
          end
        end else if (w_cs_high) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_CMD;
        end
      end
      S_WR_WAIT: begin
        if (w_cs_high) begin
          w_state_nxt = S_IDLE;
        end else if (i_rxDataValid) begin
          w_state_nxt   = S_WR_BUS;
          w_issue       = 1'b1;
          w_issue_we    = 1'b1;
          w_issue_wdata = i_rxData;
        end else begin
          w_state_nxt = S_WR_WAIT;
        end
      end
      S_WR_BUS: begin
        w_overrun = i_rxDataValid;
        if (w_cs_high) begin
          w_state_nxt = S_IDLE;
        end else if (w_bus_done) begin
          w_addr_nxt  = r_addr + 7'd1;
          w_state_nxt = S_WR_WAIT;
        end else begin
          w_state_nxt = S_WR_BUS;
        end
      end
      S_RD_BUS: begin
        w_overrun = i_rxDataValid;
        if (w_cs_high) begin
          w_state_nxt = S_IDLE;
        end else if (w_ack) begin
          w_tx_load   = 1'b1;
          w_tx_byte   = i_busRdata;
          w_state_nxt = S_RD_LOAD;
        end else if (w_timeout) begin
          w_tx_load   = 1'b1;
          w_tx_byte   = RD_ERR_BYTE;
          w_state_nxt = S_RD_LOAD;
        end else begin
          w_state_nxt = S_RD_BUS;
        end
      end
      S_RD_LOAD: begin
        w_overrun  = i_rxDataValid;
        w_addr_nxt = r_addr + 7'd1;
        if (w_cs_high) w_state_nxt = S_IDLE;
        else           w_state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (w_cs_high) begin
          w_state_nxt = S_IDLE;
        end else if (i_rxDataValid) begin
          w_state_nxt = S_RD_BUS;
          w_issue     = 1'b1;
        end else begin
          w_state_nxt = S_RD_WAIT;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM, address pointer and the tx/status output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= 7'd0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'd0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_tx_valid <= w_tx_load;
      r_tx_data  <= w_tx_byte;
      r_err      <= w_timeout | w_overrun;
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  // Bus master: request survives an FSM abort so the req/ack handshake always completes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 7'd0;
      r_bus_wdata <= 8'd0;
      r_cnt       <= '0;
    end else if (w_issue) begin
      r_bus_req   <= 1'b1;
      r_bus_we    <= w_issue_we;
      r_bus_addr  <= w_issue_addr;
      r_bus_wdata <= w_issue_wdata;
      r_cnt       <= '0;
    end else if (w_bus_done) begin
      r_bus_req <= 1'b0;
      r_cnt     <= '0;
    end else if (r_bus_req) begin
      r_cnt <= r_cnt + CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_txDataValid = r_tx_valid;
  assign o_txData      = r_tx_data;
  assign o_busReq      = r_bus_req;
  assign o_busWe       = r_bus_we;
  assign o_busAddr     = r_bus_addr;
  assign o_busWdata    = r_bus_wdata;
  assign o_busy        = r_busy;
  assign o_err         = r_err;

endmodule

// File: tb/tb_spi_reg_controller.sv
// Bench for spi_reg_controller: bench-side SPI master, bus slave with register file,
// and a frame-level reference model of expected bus accesses, tx bytes and errors.
module tb_spi_reg_controller;

  localparam int         BT     = 16;
  localparam logic [7:0] RD_ERR = 8'hEE;
  localparam int         GAP    = BT + 6;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_rxDataValid;
  logic [7:0] i_rxData;
  logic       o_txDataValid;
  logic [7:0] o_txData;
  logic       i_spiCs_n;
  logic       o_busReq;
  logic       o_busWe;
  logic [6:0] o_busAddr;
  logic [7:0] o_busWdata;
  logic       i_busAck;
  logic [7:0] i_busRdata;
  logic       o_busy;
  logic       o_err;

  spi_reg_controller #(.BUS_TIMEOUT(BT), .RD_ERR_BYTE(RD_ERR)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_rxDataValid(i_rxDataValid), .i_rxData(i_rxData),
    .o_txDataValid(o_txDataValid), .o_txData(o_txData),
    .i_spiCs_n(i_spiCs_n),
    .o_busReq(o_busReq), .o_busWe(o_busWe), .o_busAddr(o_busAddr), .o_busWdata(o_busWdata),
    .i_busAck(i_busAck), .i_busRdata(i_busRdata),
    .o_busy(o_busy), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc_cnt  = 0;
  int last_rx_cyc  = 0;
  int last_evt_cyc = 0;
  int ack_delay    = 0;
  int err_cnt  = 0;
  int exp_err  = 0;

  logic [7:0]  ref_mem   [128];
  logic [7:0]  slave_mem [128];
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  exp_tx[$];
  int          dly [8];
  logic [7:0]  dat [8];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc_cnt);
    end
  endtask

  always @(posedge i_clk) cyc_cnt <= cyc_cnt + 1;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Bus slave plus tx/err monitor, one process so timeout bookkeeping precedes the tx check
  initial begin : env
    bit          pend;
    int          wc, rq, cur_d;
    logic [15:0] lat;
    pend = 1'b0; wc = 0; rq = 0; cur_d = 0; lat = 16'd0;
    i_busAck = 1'b0;
    i_busRdata = 8'd0;
    forever begin
      @(posedge i_clk);
      #1;
      i_busAck = 1'b0;
      if (!i_rst_n) begin
        pend = 1'b0;
      end else if (o_busReq) begin
        if (!pend) begin
          pend = 1'b1; wc = 0; rq = 0; cur_d = ack_delay;
          lat = {o_busWe, o_busAddr, o_busWdata};
          check_val("req_latency", cyc_cnt - last_rx_cyc, 1);
        end else begin
          check_val("bus_stable", {o_busWe, o_busAddr, o_busWdata}, lat);
        end
        rq++;
        if (wc == cur_d) begin
          i_busAck = 1'b1;
          i_busRdata = slave_mem[lat[14:8]];
          if (lat[15]) begin
            slave_mem[lat[14:8]] = lat[7:0];
            got_q.push_back(lat);
          end else begin
            got_q.push_back({1'b0, lat[14:8], slave_mem[lat[14:8]]});
            last_evt_cyc = cyc_cnt;
          end
          pend = 1'b0;
        end
        wc++;
      end else if (pend) begin
        check_val("req_len_timeout", rq, BT);
        if (!lat[15]) last_evt_cyc = cyc_cnt - 1;
        pend = 1'b0;
      end
      if (i_rst_n && o_txDataValid) begin
        tx_q.push_back(o_txData);
        check_val("tx_latency", cyc_cnt - last_evt_cyc, 1);
      end
      if (i_rst_n && o_err) err_cnt++;
    end
  end

  task automatic pulse_rx(input logic [7:0] b);
    i_rxDataValid = 1'b1;
    i_rxData = b;
    last_rx_cyc = cyc_cnt;
    cyc(1);
    i_rxDataValid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int d);
    ack_delay = d;
    pulse_rx(b);
    cyc(GAP);
  endtask

  function automatic bit acked(input int d);
    return (d >= 0) && (d < BT);
  endfunction

  // Model: a frame is a command plus n bytes; each access either acks or times out
  task automatic run_frame(input bit rd, input logic [6:0] a, input int n);
    logic [6:0] ad;
    i_spiCs_n = 1'b0;
    cyc(5);
    check_val("busy_in_frame", o_busy, 1);
    send_byte({rd, a}, rd ? dly[0] : 0);
    for (int i = 0; i < n; i++) begin
      if (rd) send_byte(8'($urandom), dly[i+1]);
      else    send_byte(dat[i], dly[i]);
    end
    i_spiCs_n = 1'b1;
    cyc(GAP);
    check_val("idle_after_frame", o_busy, 0);
    ad = a;
    if (rd) begin
      for (int i = 0; i <= n; i++) begin
        if (acked(dly[i])) begin
          exp_q.push_back({1'b0, ad, ref_mem[ad]});
          exp_tx.push_back(ref_mem[ad]);
        end else begin
          exp_tx.push_back(RD_ERR);
          exp_err++;
        end
        ad = ad + 7'd1;
      end
    end else begin
      for (int i = 0; i < n; i++) begin
        if (acked(dly[i])) begin
          exp_q.push_back({1'b1, ad, dat[i]});
          ref_mem[ad] = dat[i];
        end else begin
          exp_err++;
        end
        ad = ad + 7'd1;
      end
    end
  endtask

  task automatic verify(input string tag);
    check_val({tag, "_n_access"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check_val({tag, "_access"}, got_q[i], exp_q[i]);
    check_val({tag, "_n_tx"}, tx_q.size(), exp_tx.size());
    for (int i = 0; i < tx_q.size() && i < exp_tx.size(); i++)
      check_val({tag, "_tx"}, tx_q[i], exp_tx[i]);
    check_val({tag, "_err_count"}, err_cnt, exp_err);
    got_q.delete(); exp_q.delete(); tx_q.delete(); exp_tx.delete();
  endtask

  initial begin : watchdog
    #2000000;
    n_fails++;
    $display("FAIL watchdog expired at cycle %0d", cyc_cnt);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

  initial begin : main
    bit         rd;
    logic [6:0] a;
    int         n;
    logic [7:0] v;
    for (int i = 0; i < 128; i++) begin
      v = 8'($urandom);
      ref_mem[i] = v;
      slave_mem[i] = v;
    end
    i_rst_n = 1'b0; i_spiCs_n = 1'b1; i_rxDataValid = 1'b0; i_rxData = 8'd0;
    cyc(3);
    check_val("reset_outputs",
              {o_busReq, o_busWe, o_busAddr, o_busWdata, o_txDataValid, o_txData, o_busy, o_err}, 0);
    i_rst_n = 1'b1;
    cyc(3);
    check_val("idle_after_reset", o_busy, 0);

    // Write frame 05, AA, 55 with ack in the second request cycle
    dly[0] = 1; dly[1] = 1; dat[0] = 8'hAA; dat[1] = 8'h55;
    run_frame(1'b0, 7'h05, 2);
    verify("write_frame");

    // Read burst 83 + two dummies over preset register contents
    ref_mem[3] = 8'h11; ref_mem[4] = 8'h22; ref_mem[5] = 8'h33;
    slave_mem[3] = 8'h11; slave_mem[4] = 8'h22; slave_mem[5] = 8'h33;
    dly[0] = 2; dly[1] = 0; dly[2] = 3;
    run_frame(1'b1, 7'h03, 2);
    verify("read_burst");

    // Address wrap 7F -> 00
    dly[0] = 0; dly[1] = 4; dat[0] = 8'hC3; dat[1] = 8'h3C;
    run_frame(1'b0, 7'h7F, 2);
    verify("wrap");

    // Read timeout at addr 00, then the next read targets 01
    dly[0] = -1; dly[1] = 2;
    run_frame(1'b1, 7'h00, 1);
    verify("read_timeout");

    // Ack in the final timeout cycle wins; one cycle later is a dropped write
    dly[0] = BT - 1; dly[1] = BT; dly[2] = 0;
    dat[0] = 8'h5A; dat[1] = 8'hA5; dat[2] = 8'h99;
    run_frame(1'b0, 7'h30, 3);
    verify("timeout_boundary");

    // Overrun: extra byte while a write is pending is dropped with an error
    i_spiCs_n = 1'b0;
    cyc(5);
    send_byte(8'h20, 0);
    ack_delay = 6;
    pulse_rx(8'h3C);
    cyc(1);
    pulse_rx(8'hFF);
    cyc(GAP);
    send_byte(8'h4D, 0);
    i_spiCs_n = 1'b1;
    cyc(GAP);
    exp_q.push_back({1'b1, 7'h20, 8'h3C}); ref_mem[7'h20] = 8'h3C;
    exp_q.push_back({1'b1, 7'h21, 8'h4D}); ref_mem[7'h21] = 8'h4D;
    exp_err++;
    verify("overrun");

    // CS released during a read: FSM idles, request held to ack, no tx load
    i_spiCs_n = 1'b0;
    cyc(5);
    ack_delay = 10;
    pulse_rx(8'hC0);
    cyc(2);
    i_spiCs_n = 1'b1;
    cyc(4);
    check_val("abort_busy", o_busy, 0);
    check_val("abort_req_held", o_busReq, 1);
    cyc(GAP);
    check_val("abort_req_done", o_busReq, 0);
    exp_q.push_back({1'b0, 7'h40, ref_mem[7'h40]});
    verify("abort");
    dly[0] = 0; dat[0] = 8'h77;
    run_frame(1'b0, 7'h41, 1);
    verify("after_abort");

    // Asynchronous reset in the middle of a read burst
    i_spiCs_n = 1'b0;
    cyc(5);
    send_byte(8'h90, 2);
    ack_delay = 12;
    pulse_rx(8'h00);
    cyc(3);
    #3;
    i_rst_n = 1'b0;
    #1;
    check_val("async_reset_outputs",
              {o_busReq, o_busWe, o_busAddr, o_busWdata, o_txDataValid, o_txData, o_busy, o_err}, 0);
    i_spiCs_n = 1'b1;
    cyc(2);
    i_rst_n = 1'b1;
    cyc(GAP);
    exp_q.push_back({1'b0, 7'h10, ref_mem[7'h10]});
    exp_tx.push_back(ref_mem[7'h10]);
    verify("async_reset");

    // Randomized frames
    for (int f = 0; f < 14; f++) begin
      rd = 1'($urandom_range(0, 1));
      a  = 7'($urandom);
      if (f % 5 == 4) a = 7'h7F;
      n  = int'($urandom_range(1, 3));
      for (int i = 0; i < 8; i++) begin
        dly[i] = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, BT - 1));
        dat[i] = 8'($urandom);
      end
      run_frame(rd, a, n);
      verify("random_frame");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
